sram_write_arbiter: RTL

- Shares the single SRAM write channel between two requesters: W0, the image buffer writer, and W1, the overlay writer.
- Each request is one 54-bit {mask[3:0], addr[17:0], data[31:0]} beat.
- Grants are round-robin and burst-locked, so a row of pixels lands in SRAM contiguously.
- Sits in the clock_10M domain in front of the SRAM arbiter's write port. Provides per-requester accepted-beat counters for LED/debug.

---
 rtl/video_pkg.sv | 21 ++
 rtl/arb_out_reg.sv | 33 +++
 rtl/sram_write_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared constants for the video write path: beat field widths, arbiter
// state encodings and requester indices.
package video_pkg;

  localparam int MASK_W  = 4;
  localparam int ADDR_W  = 18;
  localparam int WDATA_W = 32;
  localparam int DATA_W  = MASK_W + ADDR_W + WDATA_W;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  localparam logic W0 = 1'b0;
  localparam logic W1 = 1'b1;

  function automatic logic [1:0] own_state(input logic idx);
    return idx ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/arb_out_reg.sv
// Single-entry valid/ready pipeline register driving the SRAM write port.
module arb_out_reg #(
  parameter int DATA_W = 54
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_dout;
  logic              r_valid;

  // i_load is only raised while the slot is empty or being drained.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_dout  <= i_din;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_dout  = r_dout;
  assign o_valid = r_valid;

endmodule

// File: rtl/sram_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing the SRAM write channel between
// the image buffer writer (W0) and the overlay writer (W1).
module sram_write_arbiter
  import video_pkg::*;
#(
  parameter int DATA_W    = MASK_W + ADDR_W + WDATA_W,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] w0_din,
  input  logic              w0_valid,
  output logic              w0_ready,
  input  logic [DATA_W-1:0] w1_din,
  input  logic              w1_valid,
  output logic              w1_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  w0_count,
  output logic [CNT_W-1:0]  w1_count
);

  localparam int              BC_W       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);

  logic [1:0]        r_state, w_state_nxt;
  logic              r_last_owner, w_last_nxt;
  logic [BC_W-1:0]   r_burst_cnt, w_burst_nxt;
  logic [CNT_W-1:0]  r_w0_count, r_w1_count;
  logic              w_slot_free, w_acc0, w_acc1, w_acc;
  logic              w_owner, w_own_valid, w_oth_valid, w_release;
  logic [DATA_W-1:0] w_acc_din;

  assign w_slot_free = ~dout_valid | dout_ready;
  assign w0_ready    = (r_state == ST_OWN0) & w_slot_free;
  assign w1_ready    = (r_state == ST_OWN1) & w_slot_free;
  assign w_acc0      = w0_valid & w0_ready;
  assign w_acc1      = w1_valid & w1_ready;
  assign w_acc       = w_acc0 | w_acc1;
  assign w_acc_din   = w_acc1 ? w1_din : w0_din;

  assign grant    = {r_state == ST_OWN1, r_state == ST_OWN0};
  assign w0_count = r_w0_count;
  assign w1_count = r_w1_count;

  // Owner-relative view so both OWN states share one release path.
  assign w_owner     = (r_state == ST_OWN1) ? W1 : W0;
  assign w_own_valid = w_owner ? w1_valid : w0_valid;
  assign w_oth_valid = w_owner ? w0_valid : w1_valid;
  assign w_release   = ~w_own_valid | (w_acc & (r_burst_cnt == BURST_LAST));

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_owner;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      ST_OWN0, ST_OWN1: begin
        if (w_release) begin
          w_last_nxt  = w_owner;
          w_burst_nxt = '0;
          if (w_oth_valid)      w_state_nxt = own_state(~w_owner);
          else if (w_own_valid) w_state_nxt = own_state(w_owner);
          else                  w_state_nxt = ST_IDLE;
        end else if (w_acc) begin
          w_burst_nxt = r_burst_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        if (w0_valid & w1_valid) w_state_nxt = own_state(~r_last_owner);
        else if (w0_valid)       w_state_nxt = ST_OWN0;
        else if (w1_valid)       w_state_nxt = ST_OWN1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_last_owner <= W1;
      r_burst_cnt  <= '0;
      r_w0_count   <= '0;
      r_w1_count   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_nxt;
      r_burst_cnt  <= w_burst_nxt;
      if (w_acc0) r_w0_count <= r_w0_count + 1'b1;
      if (w_acc1) r_w1_count <= r_w1_count + 1'b1;
    end
  end

  arb_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_acc),
    .i_din  (w_acc_din),
    .i_ready(dout_ready),
    .o_dout (dout),
    .o_valid(dout_valid)
  );

endmodule
